vector_mem_sequencer: RTL and testbench

VECTOR_MEM_SEQUENCER -- requirements
Module: vector_mem_sequencer

---
 rtl/vector_mem_sequencer.sv | 129 ++++++++++++
 tb/tb_vector_mem_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_mem_sequencer.sv
// vector_mem_sequencer: serializes a masked THREADS-lane vector load/store
// into one-word cache accesses, lowest active lane first.
// Optional feature macro: VSEQ_COALESCE_EN. When it is defined, a single load
// hit also fills every remaining lane that has the same latched address.
module vector_mem_sequencer #(
  parameter int THREADS = 4
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     vREN,
  input  logic                     vWEN,
  input  logic [THREADS-1:0]       vmask,
  input  logic [THREADS-1:0][31:0] vaddr,
  input  logic [THREADS-1:0][31:0] vstore,
  output logic [THREADS-1:0][31:0] vload,
  output logic                     vbusy,
  output logic                     vdone,
  output logic                     dREN,
  output logic                     dWEN,
  output logic [31:0]              daddr,
  output logic [31:0]              dstore,
  input  logic [31:0]              dload,
  input  logic                     dhit
);

  localparam int PW = $clog2(THREADS);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t                   r_state;
  state_t                   w_next_state;
  logic [THREADS-1:0][31:0] r_addr;
  logic [THREADS-1:0][31:0] r_data;
  logic [THREADS-1:0][31:0] r_vload;
  logic [THREADS-1:0]       r_rem;
  logic                     r_op_load;
  logic [PW-1:0]            w_ptr;
  logic [31:0]              w_sel_addr;
  logic [THREADS-1:0]       w_match;
  logic [THREADS-1:0]       w_served;
  logic                     w_start;

  assign w_start = vREN | vWEN;
  assign vload   = r_vload;

  // Select the lowest lane that is still pending; masked lanes are skipped.
  always_comb begin
    w_ptr = '0;
    for (int i = THREADS - 1; i >= 0; i--) begin
      if (r_rem[i]) w_ptr = PW'(i);
    end
  end

  assign w_sel_addr = r_addr[w_ptr];

  // Lanes retired by a hit on the current access.
  generate
    for (genvar gi = 0; gi < THREADS; gi++) begin : g_match
`ifdef VSEQ_COALESCE_EN
      assign w_match[gi] = r_rem[gi] &&
                           ((PW'(gi) == w_ptr) ||
                            (r_op_load && (r_addr[gi] == w_sel_addr)));
`else
      assign w_match[gi] = r_rem[gi] && (PW'(gi) == w_ptr);
`endif
    end
  endgenerate

  assign w_served = ((r_state == ACCESS) && dhit) ? w_match : '0;

  // State register; reset abandons any request in flight.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state decode and cache/handshake outputs.
  always_comb begin
    w_next_state = r_state;
    vbusy        = 1'b0;
    vdone        = 1'b0;
    dREN         = 1'b0;
    dWEN         = 1'b0;
    daddr        = '0;
    dstore       = '0;
    case (r_state)
      IDLE: begin
        if (w_start) w_next_state = (vmask != '0) ? ACCESS : DONE;
      end
      ACCESS: begin
        vbusy  = 1'b1;
        dREN   = r_op_load;
        dWEN   = ~r_op_load;
        daddr  = w_sel_addr;
        dstore = r_data[w_ptr];
        if (dhit && ((r_rem & ~w_match) == '0)) w_next_state = DONE;
      end
      DONE: begin
        vdone        = 1'b1;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Request latching, pending-mask retirement and load result capture.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_addr    <= '0;
      r_data    <= '0;
      r_rem     <= '0;
      r_op_load <= 1'b0;
      r_vload   <= '0;
    end else if ((r_state == IDLE) && w_start) begin
      r_addr    <= vaddr;
      r_data    <= vstore;
      r_rem     <= vmask;
      r_op_load <= vREN;
    end else if (w_served != '0) begin
      r_rem <= r_rem & ~w_served;
      if (r_op_load) begin
        for (int i = 0; i < THREADS; i++) begin
          if (w_served[i]) r_vload[i] <= dload;
        end
      end
    end
  end

endmodule

// File: tb/tb_vector_mem_sequencer.sv
// Bench for vector_mem_sequencer: a driver issues requests and pushes the
// expected cache accesses and completion results into queues. A monitor acts
// as the cache, pops those queues and compares against the DUT.
`timescale 1ns/1ps
module tb_vector_mem_sequencer;

  localparam int T = 4;
`ifdef VSEQ_COALESCE_EN
  localparam bit COAL = 1'b1;
`else
  localparam bit COAL = 1'b0;
`endif

  logic                CLK = 1'b0;
  logic                nRST = 1'b0;
  logic                vREN = 1'b0;
  logic                vWEN = 1'b0;
  logic [T-1:0]        vmask = '0;
  logic [T-1:0][31:0]  vaddr = '0;
  logic [T-1:0][31:0]  vstore = '0;
  logic [T-1:0][31:0]  vload;
  logic                vbusy, vdone, dREN, dWEN;
  logic [31:0]         daddr, dstore;
  logic [31:0]         dload = '0;
  logic                dhit = 1'b0;

  vector_mem_sequencer #(.THREADS(T)) dut (
    .CLK(CLK), .nRST(nRST), .vREN(vREN), .vWEN(vWEN), .vmask(vmask),
    .vaddr(vaddr), .vstore(vstore), .vload(vload), .vbusy(vbusy),
    .vdone(vdone), .dREN(dREN), .dWEN(dWEN), .daddr(daddr),
    .dstore(dstore), .dload(dload), .dhit(dhit)
  );

  always #5 CLK = ~CLK;

  typedef struct { logic ld; logic [31:0] addr; logic [31:0] data; } acc_t;
  typedef struct { logic [T-1:0][31:0] vl; int base; } done_t;

  acc_t               acc_q[$];
  done_t              done_q[$];
  int                 n_checks = 0;
  int                 n_fail = 0;
  int                 cyc = 0;
  int                 done_cnt = 0;
  int                 stalls = 0;
  bit                 free_run = 1'b0;
  int                 hit_mode = 0;
  logic [31:0]        stall_addr = '0;
  int                 stall_left = 0;
  logic [T-1:0][31:0] exp_vload = '0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge CLK) cyc <= cyc + 1;

  // Monitor / cache model: answers requests and checks against the queues.
  logic        m_cur, m_prev_pend, m_prev_ren;
  logic [31:0] m_prev_addr, m_prev_data;
  acc_t        m_x;
  done_t       m_d;
  initial begin
    m_prev_pend = 1'b0; m_prev_ren = 1'b0; m_prev_addr = '0; m_prev_data = '0;
  end
  always @(negedge CLK) begin
    if (!nRST) begin
      dhit = 1'b0;
      m_prev_pend = 1'b0;
      stalls = 0;
    end else begin
      m_cur = dREN | dWEN;
      chk("vbusy_vs_req", {31'd0, vbusy}, {31'd0, m_cur});
      if (m_cur) chk("single_op", {31'd0, dREN & dWEN}, 32'd0);
      if (m_prev_pend) begin
        chk("hold_req", {31'd0, m_cur}, 32'd1);
        chk("hold_addr", daddr, m_prev_addr);
        chk("hold_op", {31'd0, dREN}, {31'd0, m_prev_ren});
        chk("hold_data", dstore, m_prev_data);
      end
      if (!m_cur) dhit = 1'b0;
      else if (stall_left > 0 && daddr == stall_addr) begin
        dhit = 1'b0;
        stall_left--;
      end else if (hit_mode == 1) dhit = ($urandom_range(0, 3) != 0);
      else dhit = 1'b1;
      dload = daddr + 32'd1;
      if (m_cur && !free_run) begin
        if (dhit) begin
          if (acc_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_access: got addr %h expected none", daddr);
          end else begin
            m_x = acc_q.pop_front();
            chk("acc_op", {31'd0, dREN}, {31'd0, m_x.ld});
            chk("acc_addr", daddr, m_x.addr);
            if (!m_x.ld) chk("acc_data", dstore, m_x.data);
            $display("access %s addr=%h data=%h", dREN ? "load " : "store", daddr,
                     dREN ? dload : dstore);
          end
        end else stalls++;
      end
      m_prev_pend = m_cur && !dhit;
      m_prev_addr = daddr;
      m_prev_ren  = dREN;
      m_prev_data = dstore;
      if (vdone) begin
        if (free_run || done_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_vdone: got vdone=1 expected 0");
        end else begin
          m_d = done_q.pop_front();
          for (int i = 0; i < T; i++) chk("vload_lane", vload[i], m_d.vl[i]);
          chk("done_latency", cyc, m_d.base + stalls);
          $display("done vload=%h cycle=%0d", vload, cyc);
        end
        stalls = 0;
        done_cnt++;
      end
    end
  end

  // Issue one request from an IDLE cycle (at negedge+1) and wait for vdone.
  task automatic run_req(bit ld, bit both, logic [T-1:0] m,
                         logic [T-1:0][31:0] a, logic [T-1:0][31:0] d);
    logic [T-1:0] rem;
    int           p, nacc, k;
    acc_t         x;
    done_t        e;
    rem = m; nacc = 0;
    while (rem != '0) begin
      p = 0;
      for (int i = 0; i < T; i++) if (rem[i]) begin p = i; break; end
      x.ld = ld; x.addr = a[p]; x.data = d[p];
      acc_q.push_back(x);
      nacc++;
      for (int j = 0; j < T; j++) begin
        if (rem[j] && (j == p || (ld && COAL && a[j] == a[p]))) begin
          if (ld) exp_vload[j] = a[p] + 32'd1;
          rem[j] = 1'b0;
        end
      end
    end
    e.vl = exp_vload; e.base = cyc + nacc + 1;
    done_q.push_back(e);
    k = done_cnt;
    vREN = ld; vWEN = !ld || both; vmask = m; vaddr = a; vstore = d;
    @(negedge CLK); #1;
    vREN = 1'b0; vWEN = 1'b0; vmask = T'($urandom);
    for (int i = 0; i < T; i++) begin vaddr[i] = $urandom; vstore[i] = $urandom; end
    for (int c = 0; c < 300 && done_cnt == k; c++) begin
      if (vbusy && $urandom_range(0, 2) == 0) begin vREN = 1'b1; vmask = '1; end
      @(negedge CLK); #1;
      vREN = 1'b0;
    end
    if (done_cnt == k) begin
      n_checks++; n_fail++;
      $display("FAIL done_timeout: got no vdone expected one within 300 cycles");
      nRST = 1'b0; #1;
      acc_q.delete(); done_q.delete(); exp_vload = '0;
      @(negedge CLK); #1;
      nRST = 1'b1;
    end else begin
      // Start pulse during the DONE cycle must be ignored.
      vWEN = 1'b1; vmask = '1;
      @(negedge CLK); #1;
      vREN = 1'b0; vWEN = 1'b0;
    end
  endtask

  logic [T-1:0][31:0] ta, td;
  bit                 found;
  int                 k0;

  initial begin
    #1;
    chk("rst_dREN", {31'd0, dREN}, 32'd0);
    chk("rst_vbusy", {31'd0, vbusy}, 32'd0);
    chk("rst_vdone", {31'd0, vdone}, 32'd0);
    chk("rst_daddr", daddr, 32'd0);
    for (int i = 0; i < T; i++) chk("rst_vload", vload[i], 32'd0);
    repeat (2) @(negedge CLK);
    #1 nRST = 1'b1;
    @(negedge CLK); #1;

    // Full load, single-cycle hits.
    ta = {32'h1C, 32'h18, 32'h14, 32'h10};
    td = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
    run_req(1'b1, 1'b0, 4'b1111, ta, td);
    // Sparse store: vload must be untouched.
    td = {32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
    run_req(1'b0, 1'b0, 4'b0101, ta, td);
    // Empty mask completes without any access.
    run_req(1'b1, 1'b0, 4'b0000, ta, td);
    // Lane 1 waits three cycles for its hit.
    stall_addr = 32'h14; stall_left = 3;
    run_req(1'b1, 1'b0, 4'b1111, ta, td);
    // All lanes on one address (coalesces when the feature is built in).
    ta = {32'h40, 32'h40, 32'h40, 32'h40};
    run_req(1'b1, 1'b1, 4'b1111, ta, td);

    // Reset while lane 2 is being serviced.
    k0 = done_cnt; free_run = 1'b1; found = 1'b0;
    ta = {32'hAC, 32'hA8, 32'hA4, 32'hA0};
    vREN = 1'b1; vmask = '1; vaddr = ta;
    @(negedge CLK); #1;
    vREN = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (dREN && daddr == 32'hA8) found = 1'b1;
      else begin @(negedge CLK); #1; end
    end
    chk("rst_reach_lane2", {31'd0, found}, 32'd1);
    nRST = 1'b0; #1;
    chk("mid_rst_dREN", {31'd0, dREN}, 32'd0);
    chk("mid_rst_vbusy", {31'd0, vbusy}, 32'd0);
    chk("mid_rst_daddr", daddr, 32'd0);
    for (int i = 0; i < T; i++) chk("mid_rst_vload", vload[i], 32'd0);
    exp_vload = '0;
    repeat (2) @(negedge CLK);
    #1;
    nRST = 1'b1; free_run = 1'b0;
    @(negedge CLK); #1;
    chk("mid_rst_no_done", done_cnt, k0);
    ta = {32'h2C, 32'h28, 32'h24, 32'h20};
    run_req(1'b1, 1'b0, 4'b1011, ta, td);

    // Randomized traffic with random hit timing.
    hit_mode = 1;
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < T; i++) begin
        if ($urandom_range(0, 1) == 1) ta[i] = 32'h100 + 32'(4 * $urandom_range(0, 2));
        else ta[i] = $urandom;
        td[i] = $urandom;
      end
      run_req(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), T'($urandom), ta, td);
    end

    repeat (3) @(negedge CLK);
    #1;
    chk("acc_q_empty", acc_q.size(), 32'd0);
    chk("done_q_empty", done_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
